// File: rtl/apb_isp_mailbox.sv
`default_nettype none
// ============================================================================
//  Module   : apb_isp_mailbox
//  Brief    : APB3 completer mailbox. The MSS pushes ISP image words into a
//             first-word-fall-through FIFO and the fabric drains them.
//             Writes complete with zero wait states; reads take one wait
//             state and return registered data.
//             A setup phase is recognised while in IDLE, so the ACCESS state
//             is always the first access cycle on the bus.
//  Options  : APB_ISP_MAILBOX_CHECKSUM_EN - adds a running 32-bit sum of
//             accepted pushes at offset 0x0C. Without it, 0x0C reads 0.
//  Params   : DEPTH - FIFO depth in words, power of two, 4..64.
//  Revision : 1.0 - initial release
// ============================================================================
module apb_isp_mailbox #(
  parameter int DEPTH = 16
) (
  input  logic        PCLK,
  input  logic        PRESET_N,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [7:2]  PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  input  logic        FAB_RD_EN,
  output logic [31:0] FAB_RD_DATA,
  output logic        FAB_EMPTY,
  output logic        IRQ
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [5:0] ADDR_CTRL   = 6'd0;
  localparam logic [5:0] ADDR_STATUS = 6'd1;
  localparam logic [5:0] ADDR_DATA   = 6'd2;
  localparam logic [5:0] ADDR_CSUM   = 6'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic        acc_cyc, wait_cyc, wr_done, rd_stall;
  logic        ctrl_en, ctrl_irq_en, ovf, irq_q;
  logic [AW:0] wptr, rptr, count;
  logic [31:0] mem [DEPTH];
  logic        fifo_empty, fifo_full, pop, push, clr, ovf_set;
  logic        wr_err, rd_err, rerr_q;
  logic [31:0] rd_val, rdata_q, csum_rd;

  // FIFO occupancy: the extra pointer bit separates full from empty
  assign count      = wptr - rptr;
  assign fifo_empty = (wptr == rptr);
  assign fifo_full  = (count == (AW+1)'(DEPTH));
  assign pop        = FAB_RD_EN && !fifo_empty;

  assign FAB_EMPTY   = fifo_empty;
  assign FAB_RD_DATA = fifo_empty ? 32'd0 : mem[rptr[AW-1:0]];
  assign IRQ         = irq_q;

  // Bus phase tracking; an access that loses PSEL returns to IDLE untouched
  always_comb begin
    state_nxt = state;
    acc_cyc   = 1'b0;
    wait_cyc  = 1'b0;
    case (state)
      IDLE: begin
        if (PSEL && !PENABLE) state_nxt = ACCESS;
      end
      ACCESS: begin
        if (PSEL && PENABLE) begin
          acc_cyc   = 1'b1;
          state_nxt = PWRITE ? IDLE : WAIT;
        end else begin
          state_nxt = IDLE;
        end
      end
      WAIT: begin
        if (PSEL && PENABLE) wait_cyc = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign wr_done  = acc_cyc && PWRITE;
  assign rd_stall = acc_cyc && !PWRITE;

  assign PREADY  = wr_done || wait_cyc;
  assign PSLVERR = (wr_done && wr_err) || (wait_cyc && rerr_q);
  assign PRDATA  = wait_cyc ? rdata_q : 32'd0;

  // Write-side decode: error response, push/clear/overflow strobes
  always_comb begin
    wr_err  = 1'b0;
    clr     = 1'b0;
    push    = 1'b0;
    ovf_set = 1'b0;
    case (PADDR)
      ADDR_CTRL:   clr = wr_done && PWDATA[1];
      ADDR_STATUS: wr_err = 1'b0;
      ADDR_DATA: begin
        // A full FIFO only takes the word if the fabric frees a slot now
        wr_err  = !ctrl_en || (fifo_full && !pop);
        push    = wr_done && !wr_err;
        ovf_set = wr_done && fifo_full && !pop;
      end
      ADDR_CSUM:   wr_err = 1'b0;
      default:     wr_err = 1'b1;
    endcase
  end

  // Read-side decode, sampled in the first access cycle
  always_comb begin
    rd_val = 32'd0;
    rd_err = 1'b0;
    case (PADDR)
      ADDR_CTRL:   rd_val = {29'd0, ctrl_irq_en, 1'b0, ctrl_en};
      ADDR_STATUS: rd_val = {19'd0, ovf, 1'b0, 7'(count), 2'b00,
                             fifo_full, fifo_empty};
      ADDR_DATA:   rd_err = 1'b1;
      ADDR_CSUM:   rd_val = csum_rd;
      default:     rd_err = 1'b1;
    endcase
  end

  // Bus state register
  always_ff @(posedge PCLK or negedge PRESET_N) begin
    if (!PRESET_N) state <= IDLE;
    else           state <= state_nxt;
  end

  // Capture read data and error during the wait state
  always_ff @(posedge PCLK or negedge PRESET_N) begin
    if (!PRESET_N) begin
      rdata_q <= 32'd0;
      rerr_q  <= 1'b0;
    end else if (rd_stall) begin
      rdata_q <= rd_err ? 32'd0 : rd_val;
      rerr_q  <= rd_err;
    end
  end

  // Control bits, sticky overflow flag and the registered interrupt
  always_ff @(posedge PCLK or negedge PRESET_N) begin
    if (!PRESET_N) begin
      ctrl_en     <= 1'b0;
      ctrl_irq_en <= 1'b0;
      ovf         <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      if (wr_done && PADDR == ADDR_CTRL) begin
        ctrl_en     <= PWDATA[0];
        ctrl_irq_en <= PWDATA[2];
      end
      if (ovf_set)
        ovf <= 1'b1;
      else if (wr_done && PADDR == ADDR_STATUS && PWDATA[12])
        ovf <= 1'b0;
      irq_q <= ctrl_irq_en && (fifo_empty || ovf);
    end
  end

  // FIFO pointers; a clear overrides any push or pop in the same cycle
  always_ff @(posedge PCLK or negedge PRESET_N) begin
    if (!PRESET_N) begin
      wptr <= '0;
      rptr <= '0;
    end else if (clr) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  // FIFO storage; contents are don't-care while the pointers say empty
  always_ff @(posedge PCLK) begin
    if (push) mem[wptr[AW-1:0]] <= PWDATA;
  end

`ifdef APB_ISP_MAILBOX_CHECKSUM_EN
  logic [31:0] csum;

  // Running modulo-2^32 sum of accepted pushes
  always_ff @(posedge PCLK or negedge PRESET_N) begin
    if (!PRESET_N) csum <= 32'd0;
    else if (clr)  csum <= 32'd0;
    else if (push) csum <= csum + PWDATA;
  end

  assign csum_rd = csum;
`else
  assign csum_rd = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_apb_isp_mailbox.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_apb_isp_mailbox
//  Brief    : Directed self-checking bench for apb_isp_mailbox with a
//             queue-based model of the mailbox and a per-cycle comparator
//             on the fabric-side outputs and the interrupt.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_apb_isp_mailbox;

  localparam int DEPTH = 16;

  logic        PCLK      = 1'b0;
  logic        PRESET_N  = 1'b1;
  logic        PSEL      = 1'b0;
  logic        PENABLE   = 1'b0;
  logic        PWRITE    = 1'b0;
  logic [7:2]  PADDR     = '0;
  logic [31:0] PWDATA    = '0;
  logic        FAB_RD_EN = 1'b0;
  logic [31:0] PRDATA, FAB_RD_DATA;
  logic        PREADY, PSLVERR, FAB_EMPTY, IRQ;

  apb_isp_mailbox #(.DEPTH(DEPTH)) dut (
    .PCLK        (PCLK),
    .PRESET_N    (PRESET_N),
    .PSEL        (PSEL),
    .PENABLE     (PENABLE),
    .PWRITE      (PWRITE),
    .PADDR       (PADDR),
    .PWDATA      (PWDATA),
    .PRDATA      (PRDATA),
    .PREADY      (PREADY),
    .PSLVERR     (PSLVERR),
    .FAB_RD_EN   (FAB_RD_EN),
    .FAB_RD_DATA (FAB_RD_DATA),
    .FAB_EMPTY   (FAB_EMPTY),
    .IRQ         (IRQ)
  );

  always #5 PCLK = ~PCLK;

  int total = 0;
  int bad   = 0;

  // Mailbox model: word queue plus the programmer-visible flags
  logic [31:0] q[$];
  bit          m_en, m_ien, m_ovf, m_irq;
  logic [31:0] m_csum;
  bit          wr_note = 1'b0;
  logic [5:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  bit          chk_on  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic mdl_reset();
    q.delete();
    m_en = 0; m_ien = 0; m_ovf = 0; m_irq = 0; m_csum = 32'd0;
  endtask

  // Model update at each clock edge from the bench's own transaction notes
  always @(posedge PCLK) begin : mdl
    bit do_pop, full, clr, acc;
    if (PRESET_N) begin
      do_pop = FAB_RD_EN && q.size() > 0;
      full   = q.size() == DEPTH;
      m_irq  = m_ien && (q.size() == 0 || m_ovf);
      clr    = 0;
      acc    = 0;
      if (wr_note) begin
        case (wr_addr)
          6'd0: begin m_en = wr_data[0]; m_ien = wr_data[2]; clr = wr_data[1]; end
          6'd1: if (wr_data[12]) m_ovf = 0;
          6'd2: begin
            if (full && !do_pop) m_ovf = 1;
            acc = m_en && (!full || do_pop);
          end
          default: ;
        endcase
      end
      if (clr) begin
        q.delete();
        m_csum = 32'd0;
      end else begin
        if (do_pop) void'(q.pop_front());
        if (acc) begin
          q.push_back(wr_data);
          m_csum = m_csum + wr_data;
        end
      end
    end
  end

  // Fabric side and interrupt compared every cycle out of reset
  always @(negedge PCLK) begin
    if (chk_on && PRESET_N) begin
      check("fab_empty", {31'd0, FAB_EMPTY}, (q.size() == 0) ? 32'd1 : 32'd0);
      check("fab_rd_data", FAB_RD_DATA, (q.size() > 0) ? q[0] : 32'd0);
      check("irq", {31'd0, IRQ}, {31'd0, m_irq});
    end
  end

  function automatic bit exp_wr_err(input logic [5:0] a, input bit pop);
    if (a == 6'd2) return !(m_en && (q.size() < DEPTH || (pop && q.size() > 0)));
    return a > 6'd3;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [5:0] a, output bit err);
    err = 0;
    case (a)
      6'd0: return (m_en ? 32'd1 : 32'd0) + (m_ien ? 32'd4 : 32'd0);
      6'd1: return ((q.size() == 0) ? 32'd1 : 32'd0) + ((q.size() == DEPTH) ? 32'd2 : 32'd0)
                   + 32'(q.size() * 16) + (m_ovf ? 32'h1000 : 32'd0);
      6'd3: begin
`ifdef APB_ISP_MAILBOX_CHECKSUM_EN
        return m_csum;
`else
        return 32'd0;
`endif
      end
      default: begin err = 1; return 32'd0; end
    endcase
  endfunction

  task automatic apb_write(input logic [5:0] a, input logic [31:0] d, input bit pop, output bit err);
    bit e;
    @(posedge PCLK); #1;
    PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = a; PWDATA = d;
    @(posedge PCLK); #1;
    PENABLE = 1; FAB_RD_EN = pop;
    e = exp_wr_err(a, pop);
    wr_addr = a; wr_data = d; wr_note = 1;
    #1;
    check("wr_pready", {31'd0, PREADY}, 32'd1);
    check("wr_pslverr", {31'd0, PSLVERR}, {31'd0, e});
    check("wr_prdata", PRDATA, 32'd0);
    err = PSLVERR;
    @(posedge PCLK); #1;
    PSEL = 0; PENABLE = 0; FAB_RD_EN = 0; wr_note = 0;
  endtask

  task automatic apb_read(input logic [5:0] a, output logic [31:0] data, output bit err);
    logic [31:0] ev;
    bit ee;
    @(posedge PCLK); #1;
    PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = a;
    @(posedge PCLK); #1;
    PENABLE = 1;
    #1;
    ev = exp_rd(a, ee);
    check("rd_wait_pready", {31'd0, PREADY}, 32'd0);
    check("rd_wait_prdata", PRDATA, 32'd0);
    check("rd_wait_pslverr", {31'd0, PSLVERR}, 32'd0);
    @(posedge PCLK); #2;
    check("rd_pready", {31'd0, PREADY}, 32'd1);
    check("rd_prdata", PRDATA, ev);
    check("rd_pslverr", {31'd0, PSLVERR}, {31'd0, ee});
    data = PRDATA; err = PSLVERR;
    @(posedge PCLK); #1;
    PSEL = 0; PENABLE = 0;
  endtask

  task automatic fab_pop(input logic [31:0] exp_word);
    @(posedge PCLK); #1;
    FAB_RD_EN = 1;
    #1 check("pop_head", FAB_RD_DATA, exp_word);
    @(posedge PCLK); #1;
    FAB_RD_EN = 0;
  endtask

  initial begin : main
    logic [31:0] rd;
    bit er;
    mdl_reset();
    #2 PRESET_N = 0;
    #1;
    check("rst_pready", {31'd0, PREADY}, 32'd0);
    check("rst_pslverr", {31'd0, PSLVERR}, 32'd0);
    check("rst_prdata", PRDATA, 32'd0);
    check("rst_empty", {31'd0, FAB_EMPTY}, 32'd1);
    check("rst_rd_data", FAB_RD_DATA, 32'd0);
    check("rst_irq", {31'd0, IRQ}, 32'd0);
    repeat (2) @(posedge PCLK);
    #1 PRESET_N = 1; chk_on = 1;

    // STATUS straight out of reset
    apb_read(6'd1, rd, er);
    check("status_reset", rd, 32'h0000_0001);
    check("status_reset_err", {31'd0, er}, 32'd0);

    // Enable with interrupt; empty FIFO raises IRQ
    apb_write(6'd0, 32'h5, 0, er);
    repeat (2) @(posedge PCLK);
    #1 check("irq_on_empty", {31'd0, IRQ}, 32'd1);

    // Two pushes, then drain in order
    apb_write(6'd2, 32'h1111_1111, 0, er);
    check("push1_err", {31'd0, er}, 32'd0);
    apb_write(6'd2, 32'h2222_2222, 0, er);
    apb_read(6'd1, rd, er);
    check("status_cnt2", rd, 32'h0000_0020);
    fab_pop(32'h1111_1111);
    fab_pop(32'h2222_2222);
    #1 check("empty_after_pops", {31'd0, FAB_EMPTY}, 32'd1);

    // Error responses without side effects
    apb_read(6'd2, rd, er);
    check("rd_data_err", {31'd0, er}, 32'd1);
    check("rd_data_val", rd, 32'd0);
    apb_read(6'd4, rd, er);
    check("rd_unmapped_err", {31'd0, er}, 32'd1);
    apb_write(6'd5, 32'hFFFF_FFFF, 0, er);
    check("wr_unmapped_err", {31'd0, er}, 32'd1);
    apb_read(6'd0, rd, er);
    check("ctrl_intact", rd, 32'h0000_0005);

    // Fill to full, overflow, then W1C the overflow flag
    for (int i = 0; i < DEPTH; i++) apb_write(6'd2, 32'hA000_0000 + i, 0, er);
    apb_read(6'd1, rd, er);
    check("status_full", rd, 32'h0000_0102);
    check("irq_off_full", {31'd0, IRQ}, 32'd0);
    apb_write(6'd2, 32'hDEAD_BEEF, 0, er);
    check("overflow_err", {31'd0, er}, 32'd1);
    apb_read(6'd1, rd, er);
    check("status_ovf", rd, 32'h0000_1102);
    check("irq_on_ovf", {31'd0, IRQ}, 32'd1);
    apb_write(6'd1, 32'h0000_1000, 0, er);
    apb_read(6'd1, rd, er);
    check("status_w1c", rd, 32'h0000_0102);

    // Full FIFO: push with a simultaneous pop is accepted
    apb_write(6'd2, 32'h5555_AAAA, 1, er);
    check("full_push_pop_err", {31'd0, er}, 32'd0);
    apb_read(6'd1, rd, er);
    check("status_full_pp", rd, 32'h0000_0102);

    // Disabled mailbox rejects pushes
    fab_pop(32'hA000_0001);
    apb_write(6'd0, 32'h4, 0, er);
    apb_write(6'd2, 32'h1234_5678, 0, er);
    check("disabled_err", {31'd0, er}, 32'd1);
    apb_read(6'd1, rd, er);
    check("status_cnt15", rd, 32'h0000_00F0);
    apb_write(6'd0, 32'h5, 0, er);

    // Clear with a simultaneous pop keeps OVF
    apb_write(6'd2, 32'h7777_0000, 0, er);
    apb_write(6'd2, 32'h8888_0000, 0, er);
    check("overflow2_err", {31'd0, er}, 32'd1);
    apb_write(6'd0, 32'h7, 1, er);
    apb_read(6'd1, rd, er);
    check("status_clr", rd, 32'h0000_1001);
    apb_read(6'd0, rd, er);
    check("ctrl_clr_selfclear", rd, 32'h0000_0005);
    apb_write(6'd1, 32'h0000_1000, 0, er);

`ifdef APB_ISP_MAILBOX_CHECKSUM_EN
    apb_write(6'd2, 32'hFFFF_FFFF, 0, er);
    apb_write(6'd2, 32'h0000_0002, 0, er);
    apb_read(6'd3, rd, er);
    check("checksum", rd, 32'h0000_0001);
    apb_write(6'd0, 32'h7, 0, er);
    apb_read(6'd3, rd, er);
    check("checksum_clr", rd, 32'h0000_0000);
`else
    apb_read(6'd3, rd, er);
    check("checksum_absent", rd, 32'h0000_0000);
    check("checksum_absent_err", {31'd0, er}, 32'd0);
`endif

    // Pointer wrap: steady push/pop well past DEPTH
    for (int i = 0; i < 40; i++) apb_write(6'd2, 32'hC000_0000 + i, (i >= 3), er);
    apb_read(6'd1, rd, er);
    check("status_wrap", rd, 32'h0000_0030);
    check("head_wrap", FAB_RD_DATA, 32'hC000_0025);

    // Write abandoned after setup has no effect
    @(posedge PCLK); #1;
    PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 6'd2; PWDATA = 32'hBAD0_BAD0;
    @(posedge PCLK); #1;
    PSEL = 0;
    #1 check("abort_pready", {31'd0, PREADY}, 32'd0);
    apb_read(6'd1, rd, er);
    check("status_abort", rd, 32'h0000_0030);

    // Reset asserted in a read wait state
    @(posedge PCLK); #1;
    PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = 6'd1;
    @(posedge PCLK); #1;
    PENABLE = 1;
    #1 PRESET_N = 0;
    mdl_reset();
    #1;
    check("rst_wait_pready", {31'd0, PREADY}, 32'd0);
    check("rst_wait_prdata", PRDATA, 32'd0);
    @(posedge PCLK); #2;
    check("rst_no_complete", {31'd0, PREADY}, 32'd0);
    check("rst_fifo_empty", {31'd0, FAB_EMPTY}, 32'd1);
    PSEL = 0; PENABLE = 0;
    @(posedge PCLK); #1;
    PRESET_N = 1;
    apb_read(6'd1, rd, er);
    check("status_after_rst", rd, 32'h0000_0001);
    apb_read(6'd0, rd, er);
    check("ctrl_after_rst", rd, 32'h0000_0000);

    repeat (2) @(posedge PCLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/apb_isp_mailbox.md
APB_ISP_MAILBOX -- requirements
Module: apb_isp_mailbox

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO depth in 32-bit words, power of two, 4..64.
REQ-002 SHALL have these ports:
- PCLK in 1: single clock.
- PRESET_N in 1: asynchronous, active-low reset.
- PSEL in 1: APB3 select.
- PENABLE in 1: APB3 enable.
- PWRITE in 1: APB3 write.
- PADDR in [7:2]: word address.
- PWDATA in 32: write data.
- PRDATA out 32: read data.
- PREADY out 1: transfer complete.
- PSLVERR out 1: transfer error.
- FAB_RD_EN in 1: fabric pop request.
- FAB_RD_DATA out 32: FIFO head word.
- FAB_EMPTY out 1: FIFO empty.
- IRQ out 1: level interrupt.

Function
REQ-003 SHALL act as an APB3 completer for the MSS FIC_2 APB master; the MSS pushes ISP image words, the fabric drains them.
REQ-004 SHALL use an FSM IDLE -> SETUP (PSEL & !PENABLE) -> ACCESS (PSEL & PENABLE) -> IDLE, with a WAIT state on reads only.
REQ-005 SHALL complete writes with zero wait states: PREADY=1 in the first ACCESS cycle.
REQ-006 SHALL complete reads with exactly one wait state: PREADY=0 in the first ACCESS cycle; PREADY=1 with registered PRDATA in the second.
REQ-007 SHALL drive PRDATA=0 whenever PREADY=0 or no read completes.
REQ-008 SHALL assert PSLVERR only in the completing cycle; otherwise PSLVERR=0.
REQ-009 SHALL decode the register map (word offsets):
- 0x00 CTRL RW: bit0 ENABLE, bit1 FIFO_CLR (self-clearing, reads 0), bit2 IRQ_EN.
- 0x04 STATUS R/W1C: bit0 EMPTY, bit1 FULL, bits[10:4] COUNT, bit12 OVF (sticky, W1C).
- 0x08 DATA WO: write pushes PWDATA.
- 0x0C CHECKSUM RO (see Configuration).
REQ-010 SHALL, on a DATA write when ENABLE=0 or the FIFO is full, push nothing and raise PSLVERR; on full, also set OVF.
REQ-011 SHALL, on a read of DATA, return 0 with PSLVERR=1.
REQ-012 SHALL, on an unmapped offset, respond PSLVERR=1 (read data 0) with no side effects.
REQ-013 SHALL present FAB_RD_DATA as the head word (first-word-fall-through); FAB_RD_EN pops at the clock edge while !FAB_EMPTY; FAB_RD_EN is ignored when empty.
REQ-014 SHALL, on a push and a pop in the same cycle, keep COUNT unchanged; when full, the push is accepted only if a pop occurs in that cycle.
REQ-015 SHALL, on FIFO_CLR, empty the FIFO (COUNT=0) on the next edge; a clear wins over a simultaneous push or pop and does not clear OVF.
REQ-016 SHALL wrap read/write pointers modulo DEPTH, using an extra pointer bit to distinguish full from empty.
REQ-017 SHALL drive IRQ = IRQ_EN & (FAB_EMPTY | OVF), registered, one cycle after the cause.
REQ-018 SHALL return to IDLE without completing if PSEL deasserts mid-transfer, with no register or FIFO side effects.

Reset
REQ-019 SHALL, on PRESET_N low, immediately force:
- FSM to IDLE; PREADY=0, PSLVERR=0, PRDATA=0;
- CTRL=0; FIFO empty (FAB_EMPTY=1, FAB_RD_DATA=0); OVF=0; CHECKSUM=0; IRQ=0.
REQ-020 SHALL abort any in-flight transfer on reset; FIFO contents are not preserved.

Configuration
REQ-021 SHALL use macro APB_ISP_MAILBOX_CHECKSUM_EN:
- Defined: CHECKSUM is the 32-bit modulo-2^32 sum of every accepted pushed word, cleared by FIFO_CLR and reset.
- Undefined: offset 0x0C reads 0 with PSLVERR=0 and the adder is absent.

Verification
REQ-022 Reset then read STATUS -> PREADY low 1 cycle, PRDATA=0x00000001, PSLVERR=0.
REQ-023 ENABLE=1, write DATA 0x11111111 and 0x22222222 -> COUNT=2; fabric pops return 0x11111111 then 0x22222222; FAB_EMPTY=1 after.
REQ-024 Push 17 words with DEPTH=16 -> 17th write PSLVERR=1, OVF=1, IRQ=1 (IRQ_EN=1); W1C 0x1000 to STATUS clears OVF.
REQ-025 FIFO full, DATA write and FAB_RD_EN in the same cycle -> write accepted, PSLVERR=0, COUNT stays 16.
REQ-026 With CHECKSUM_EN, push 0xFFFFFFFF and 0x00000002 -> CHECKSUM=0x00000001; after FIFO_CLR -> 0.
REQ-027 PRESET_N low during a read wait state -> PREADY=0 and PRDATA=0 immediately; the next read completes normally.
